// File: rtl/flag_pkg.sv
// Shared definitions for the flag stack unit.
//   - Flag bit indices (C and Z).
//   - Default parameter values for the flag count and shadow stack depth.
//   - shad_op_t: the shadow stack operation decoded once per cycle
//     from the push/pop requests.
package flag_pkg;

    localparam int FLG_C_IDX      = 0;
    localparam int FLG_Z_IDX      = 1;

    localparam int NUM_FLAGS_DEF  = 2;
    localparam int SHAD_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        SH_NONE,
        SH_PUSH,
        SH_POP,
        SH_SWAP
    } shad_op_t;

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO shadow stack of the flag vector, used to nest interrupts.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   op           decoded operation for this cycle (none/push/pop/swap)
//   push_data    current registered flag vector (value saved on push/swap)
//   err_clr      clears the sticky overflow/underflow bits
//   top_data     contents of the top valid entry
//   push_taken   an entry is written this cycle
//   pop_taken    the flag register must load top_data this cycle
//   count        number of valid entries
//   empty, full  decodes of count
//   ovf, unf     sticky error bits (push while full / pop while empty)
module flag_shadow_stack
    import flag_pkg::*;
#(
    parameter int NUM_FLAGS  = NUM_FLAGS_DEF,
    parameter int SHAD_DEPTH = SHAD_DEPTH_DEF,
    parameter int CNT_W      = $clog2(SHAD_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  shad_op_t             op,
    input  logic [NUM_FLAGS-1:0] push_data,
    input  logic                 err_clr,
    output logic [NUM_FLAGS-1:0] top_data,
    output logic                 push_taken,
    output logic                 pop_taken,
    output logic [CNT_W-1:0]     count,
    output logic                 empty,
    output logic                 full,
    output logic                 ovf,
    output logic                 unf
);

    localparam int IDX_W = (SHAD_DEPTH > 1) ? $clog2(SHAD_DEPTH) : 1;

    logic [NUM_FLAGS-1:0] entry_reg [SHAD_DEPTH];
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic                 ovf_reg;
    logic                 unf_reg;
    logic                 ovf_set;
    logic                 unf_set;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     top_idx;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(SHAD_DEPTH));
    assign top_idx = IDX_W'(count_reg - CNT_W'(1));
    // Only meaningful when not empty; the flag register ignores it otherwise.
    assign top_data = entry_reg[top_idx];

    always_comb begin
        push_taken = 1'b0;
        pop_taken  = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = IDX_W'(count_reg);
        count_next = count_reg;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case (op)
            SH_PUSH: begin
                if (!full) begin
                    wr_en      = 1'b1;
                    push_taken = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                end else begin
                    ovf_set = 1'b1;
                end
            end
            SH_POP: begin
                if (!empty) begin
                    pop_taken  = 1'b1;
                    count_next = count_reg - CNT_W'(1);
                end else begin
                    unf_set = 1'b1;
                end
            end
            SH_SWAP: begin
                if (!empty) begin
                    // Exchange flags with the top entry; depth unchanged.
                    wr_en      = 1'b1;
                    wr_idx     = top_idx;
                    push_taken = 1'b1;
                    pop_taken  = 1'b1;
                end else begin
                    // Nothing to pop: behaves as a push and flags underflow.
                    // An empty stack is never full since depth >= 1.
                    wr_en      = 1'b1;
                    push_taken = 1'b1;
                    count_next = count_reg + CNT_W'(1);
                    unf_set    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < SHAD_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg[gi] <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            // A fresh error beats a simultaneous clear.
            ovf_reg   <= ovf_set | (ovf_reg & ~err_clr);
            unf_reg   <= unf_set | (unf_reg & ~err_clr);
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;
    assign unf   = unf_reg;

endmodule

// File: rtl/flag_stack_unit.sv
// Architectural flag register with per-flag clear/load/set controls and a
// shadow stack for nested interrupt save/restore.
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   FLG_CLR/FLG_LD/FLG_SET     per-flag controls, priority CLR > LD > SET
//   FLG_IN                     ALU flag values used by FLG_LD
//   FLG_PUSH, FLG_POP          save flags (interrupt entry) / restore (RETIE)
//   ERR_CLR                    clears SHAD_OVF and SHAD_UNF
//   FLAGS                      registered flags
//   SHAD_COUNT/EMPTY/FULL      shadow stack occupancy
//   SHAD_OVF, SHAD_UNF         sticky overflow / underflow
module flag_stack_unit
    import flag_pkg::*;
#(
    parameter int NUM_FLAGS  = NUM_FLAGS_DEF,
    parameter int SHAD_DEPTH = SHAD_DEPTH_DEF,
    parameter int CNT_W      = $clog2(SHAD_DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NUM_FLAGS-1:0] FLG_CLR,
    input  logic [NUM_FLAGS-1:0] FLG_LD,
    input  logic [NUM_FLAGS-1:0] FLG_SET,
    input  logic [NUM_FLAGS-1:0] FLG_IN,
    input  logic                 FLG_PUSH,
    input  logic                 FLG_POP,
    input  logic                 ERR_CLR,
    output logic [NUM_FLAGS-1:0] FLAGS,
    output logic [CNT_W-1:0]     SHAD_COUNT,
    output logic                 SHAD_EMPTY,
    output logic                 SHAD_FULL,
    output logic                 SHAD_OVF,
    output logic                 SHAD_UNF
);

    logic [NUM_FLAGS-1:0] flags_reg;
    logic [NUM_FLAGS-1:0] flags_next;
    logic [NUM_FLAGS-1:0] upd_flags;
    logic [NUM_FLAGS-1:0] top_data;
    logic                 push_taken;
    logic                 pop_taken;
    shad_op_t             shad_op;

    always_comb begin
        case ({FLG_PUSH, FLG_POP})
            2'b10:   shad_op = SH_PUSH;
            2'b01:   shad_op = SH_POP;
            2'b11:   shad_op = SH_SWAP;
            default: shad_op = SH_NONE;
        endcase
    end

    flag_shadow_stack #(
        .NUM_FLAGS  (NUM_FLAGS),
        .SHAD_DEPTH (SHAD_DEPTH),
        .CNT_W      (CNT_W)
    ) u_stack (
        .clk        (CLK),
        .rst_n      (RST_N),
        .op         (shad_op),
        .push_data  (flags_reg),
        .err_clr    (ERR_CLR),
        .top_data   (top_data),
        .push_taken (push_taken),
        .pop_taken  (pop_taken),
        .count      (SHAD_COUNT),
        .empty      (SHAD_EMPTY),
        .full       (SHAD_FULL),
        .ovf        (SHAD_OVF),
        .unf        (SHAD_UNF)
    );

    generate
        for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
            always_comb begin
                if (FLG_CLR[gi])      upd_flags[gi] = 1'b0;
                else if (FLG_LD[gi])  upd_flags[gi] = FLG_IN[gi];
                else if (FLG_SET[gi]) upd_flags[gi] = 1'b1;
                else                  upd_flags[gi] = flags_reg[gi];
            end
        end
    endgenerate

    // Any taken pop (plain or swap) restores the top entry and overrides the
    // per-flag controls; a push alone leaves the per-flag update in force.
    always_comb begin
        case ({push_taken, pop_taken})
            2'b01, 2'b11: flags_next = top_data;
            default:      flags_next = upd_flags;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_reg <= '0;
        end else begin
            flags_reg <= flags_next;
        end
    end

    assign FLAGS = flags_reg;

endmodule

// File: tb/tb_flag_stack_unit.sv
module tb_flag_stack_unit;
    import flag_pkg::*;

    localparam int NF    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NF-1:0] flg_clr, flg_ld, flg_set, flg_in;
    logic          flg_push, flg_pop, err_clr;
    logic [NF-1:0] flags;
    logic [CW-1:0] shad_count;
    logic          shad_empty, shad_full, shad_ovf, shad_unf;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue for the stack, plain variables for the rest.
    logic [NF-1:0] m_flags;
    logic [NF-1:0] m_q[$];
    logic          m_ovf, m_unf;

    flag_stack_unit #(.NUM_FLAGS(NF), .SHAD_DEPTH(DEPTH)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .FLG_CLR    (flg_clr),
        .FLG_LD     (flg_ld),
        .FLG_SET    (flg_set),
        .FLG_IN     (flg_in),
        .FLG_PUSH   (flg_push),
        .FLG_POP    (flg_pop),
        .ERR_CLR    (err_clr),
        .FLAGS      (flags),
        .SHAD_COUNT (shad_count),
        .SHAD_EMPTY (shad_empty),
        .SHAD_FULL  (shad_full),
        .SHAD_OVF   (shad_ovf),
        .SHAD_UNF   (shad_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step();
        int n;
        logic [NF-1:0] old_flags;
        logic [NF-1:0] t;
        logic new_ovf, new_unf;
        n = m_q.size();
        old_flags = m_flags;
        new_ovf = flg_push && !flg_pop && (n == DEPTH);
        new_unf = flg_pop && (n == 0);
        if (flg_pop && n > 0) begin
            t = m_q[n-1];
            if (flg_push) m_q[n-1] = old_flags;
            else          void'(m_q.pop_back());
            m_flags = t;
        end else begin
            for (int i = 0; i < NF; i++) begin
                if (flg_clr[i])      m_flags[i] = 1'b0;
                else if (flg_ld[i])  m_flags[i] = flg_in[i];
                else if (flg_set[i]) m_flags[i] = 1'b1;
            end
            if (flg_push && n < DEPTH) m_q.push_back(old_flags);
        end
        m_ovf = (err_clr ? 1'b0 : m_ovf) | new_ovf;
        m_unf = (err_clr ? 1'b0 : m_unf) | new_unf;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".flags"}, 32'(flags), 32'(m_flags));
        chk({tag, ".count"}, 32'(shad_count), 32'(m_q.size()));
        chk({tag, ".empty"}, 32'(shad_empty), 32'(m_q.size() == 0));
        chk({tag, ".full"},  32'(shad_full), 32'(m_q.size() == DEPTH));
        chk({tag, ".ovf"},   32'(shad_ovf), 32'(m_ovf));
        chk({tag, ".unf"},   32'(shad_unf), 32'(m_unf));
    endtask

    task automatic step(input string tag, input logic [NF-1:0] c, input logic [NF-1:0] l,
                        input logic [NF-1:0] s, input logic [NF-1:0] i,
                        input logic pu, input logic po, input logic ec);
        flg_clr = c; flg_ld = l; flg_set = s; flg_in = i;
        flg_push = pu; flg_pop = po; err_clr = ec;
        @(posedge clk);
        #1;
        model_step();
        check_all(tag);
        $display("[TB] %s clr=%b ld=%b set=%b in=%b push=%b pop=%b eclr=%b -> flags=%b cnt=%0d ovf=%b unf=%b",
                 tag, c, l, s, i, pu, po, ec, flags, shad_count, shad_ovf, shad_unf);
    endtask

    task automatic idle_inputs();
        flg_clr = '0; flg_ld = '0; flg_set = '0; flg_in = '0;
        flg_push = 1'b0; flg_pop = 1'b0; err_clr = 1'b0;
    endtask

    // Assert reset between edges and check it takes effect without a clock.
    task automatic async_reset(input string tag);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        chk({tag, ".flags0"}, 32'(flags), 32'(0));
        chk({tag, ".empty1"}, 32'(shad_empty), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, ".post"});
        $display("[TB] %s async reset -> flags=%b cnt=%0d", tag, flags, shad_count);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset_rel");

        // 1: set, then clear beats load
        step("tp1_set", 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0);
        chk("tp1_set_k", 32'(flags), 32'(2'b11));
        step("tp1_clr", 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0);
        chk("tp1_clr_k", 32'(flags), 32'(2'b10));

        // 2: push saves pre-edge flags while load applies; pop overrides set
        step("tp2_prep", 2'b00, 2'b11, 2'b00, 2'b01, 0, 0, 0);
        step("tp2_push", 2'b00, 2'b11, 2'b00, 2'b10, 1, 0, 0);
        chk("tp2_push_k", 32'(flags), 32'(2'b10));
        chk("tp2_cnt_k", 32'(shad_count), 32'(1));
        step("tp2_pop", 2'b00, 2'b00, 2'b11, 2'b00, 0, 1, 0);
        chk("tp2_pop_k", 32'(flags), 32'(2'b01));
        chk("tp2_empty_k", 32'(shad_empty), 32'(1));

        // 3: fill, overflow, drain
        step("tp3_ld", 2'b00, 2'b11, 2'b00, 2'b00, 0, 0, 0);
        step("tp3_p0", 2'b00, 2'b11, 2'b00, 2'b01, 1, 0, 0);
        step("tp3_p1", 2'b00, 2'b11, 2'b00, 2'b10, 1, 0, 0);
        step("tp3_p2", 2'b00, 2'b11, 2'b00, 2'b11, 1, 0, 0);
        step("tp3_p3", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        chk("tp3_full_k", 32'(shad_full), 32'(1));
        step("tp3_p4", 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
        chk("tp3_ovf_k", 32'(shad_ovf), 32'(1));
        chk("tp3_cnt_k", 32'(shad_count), 32'(4));
        for (int k = 0; k < 4; k++) begin
            step("tp3_pop", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
            chk("tp3_pop_k", 32'(flags), 32'(3 - k));
        end

        // 4: underflow, clear, clear-vs-new-error
        step("tp4_unf", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("tp4_unf_k", 32'(shad_unf), 32'(1));
        chk("tp4_flags_k", 32'(flags), 32'(2'b00));
        step("tp4_eclr", 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
        chk("tp4_eclr_k", 32'(shad_unf), 32'(0));
        chk("tp4_ovfclr_k", 32'(shad_ovf), 32'(0));
        step("tp4_both", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 1);
        chk("tp4_both_k", 32'(shad_unf), 32'(1));

        // 5: swap
        step("tp5_ld", 2'b00, 2'b11, 2'b00, 2'b10, 0, 0, 1);
        step("tp5_push", 2'b00, 2'b11, 2'b00, 2'b01, 1, 0, 0);
        step("tp5_swap", 2'b11, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        chk("tp5_swap_k", 32'(flags), 32'(2'b10));
        chk("tp5_cnt_k", 32'(shad_count), 32'(1));
        step("tp5_pop", 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        chk("tp5_entry_k", 32'(flags), 32'(2'b01));

        // swap on empty stack: acts as push plus underflow
        step("swap_empty", 2'b00, 2'b00, 2'b10, 2'b00, 1, 1, 0);

        // 6: asynchronous reset mid-operation
        step("tp6_p0", 2'b00, 2'b00, 2'b01, 2'b00, 1, 0, 0);
        step("tp6_p1", 2'b00, 2'b00, 2'b10, 2'b00, 1, 0, 0);
        async_reset("tp6_rst");

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [NF-1:0] c, l, s, i;
            logic pu, po, ec;
            c  = NF'($urandom & $urandom);
            l  = NF'($urandom);
            s  = NF'($urandom);
            i  = NF'($urandom);
            pu = ($urandom_range(0, 2) == 0);
            po = ($urandom_range(0, 2) == 0);
            ec = ($urandom_range(0, 7) == 0);
            step("rnd", c, l, s, i, pu, po, ec);
            if (n == 200) async_reset("rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flag_stack_unit.md
Name: flag_stack_unit

Overview:
- Parametrised successor to the CPU's two-bit C/Z flag register.
- Holds NUM_FLAGS architectural flags with per-flag set, clear and load controls.
- Adds a SHAD_DEPTH-deep LIFO shadow stack of the flag vector, so interrupts can nest: push on interrupt entry, pop on RETIE.
- Sits between the ALU flag outputs and the control unit / branch logic.

Parameters:
- NUM_FLAGS, 2: number of flags. Bit 0 = C, bit 1 = Z by package constant.
- SHAD_DEPTH, 4: shadow stack entries. Must be ≥1.
- CNT_W, $clog2(SHAD_DEPTH+1): width of the occupancy count. Derived; not overridden.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- FLG_CLR  in  NUM_FLAGS  per-flag clear.
- FLG_LD  in  NUM_FLAGS  per-flag load from FLG_IN.
- FLG_SET  in  NUM_FLAGS  per-flag set.
- FLG_IN  in  NUM_FLAGS  ALU-produced flag values (C, Z, ...).
- FLG_PUSH  in  1  save the current flag vector to the shadow stack (interrupt entry).
- FLG_POP  in  1  restore the flag vector from the stack top (RETIE).
- ERR_CLR  in  1  clears the sticky error bits.
- FLAGS  out  NUM_FLAGS  registered architectural flags.
- SHAD_COUNT  out  CNT_W  number of valid stack entries.
- SHAD_EMPTY  out  1  SHAD_COUNT == 0.
- SHAD_FULL  out  1  SHAD_COUNT == SHAD_DEPTH.
- SHAD_OVF  out  1  sticky: a push was attempted while full.
- SHAD_UNF  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset, asynchronous on RST_N low:
  - FLAGS=0, SHAD_COUNT=0, all stack entries=0, SHAD_OVF=0, SHAD_UNF=0.
  - SHAD_EMPTY=1; SHAD_FULL=0.
  - Reset mid-push/pop aborts the operation; no partial state survives.
- Per-flag update, each bit i independently, when no pop is taken:
  - Priority is CLR > LD > SET > hold.
  - FLAGS[i] <= 0 / FLG_IN[i] / 1 / FLAGS[i].
  - Latency: one cycle; FLAGS changes on the edge following the asserted control.
- Push only (FLG_PUSH=1, FLG_POP=0):
  - If not full: entry[SHAD_COUNT] <= FLAGS (pre-edge registered value); SHAD_COUNT+1.
  - Per-flag updates still apply to FLAGS in the same cycle.
  - If full: stack and count unchanged; SHAD_OVF <= 1; per-flag updates still apply.
- Pop only (FLG_POP=1, FLG_PUSH=0):
  - If not empty: FLAGS <= entry[SHAD_COUNT-1]; SHAD_COUNT-1.
  - A taken pop overrides all per-flag controls that cycle.
  - If empty: SHAD_UNF <= 1; count unchanged; per-flag updates apply normally.
- Push and pop together:
  - Count > 0 (swap): FLAGS <= entry[top]; entry[top] <= old FLAGS; count unchanged; per-flag controls ignored.
  - Count == 0: push behaviour only, and SHAD_UNF <= 1.
- Sticky error bits:
  - ERR_CLR clears SHAD_OVF and SHAD_UNF.
  - A new error in the same cycle as ERR_CLR wins, so the bit stays 1.
- Entries at or above SHAD_COUNT are don't-care; they are not cleared on pop.
- SHAD_EMPTY and SHAD_FULL are combinational decodes of the registered SHAD_COUNT.
- No combinational path from any input to FLAGS.

Decomposition:
- Package flag_pkg:
  - Index constants FLG_C_IDX=0 and FLG_Z_IDX=1.
  - Default NUM_FLAGS and SHAD_DEPTH.
  - Enum shad_op_t {SH_NONE, SH_PUSH, SH_POP, SH_SWAP}, decoded once per cycle.
- Sub-module flag_shadow_stack holds the LIFO storage, count, full/empty and error flags.
  - It is parametrised by NUM_FLAGS and SHAD_DEPTH.
  - It exposes top-of-stack data and taken-push / taken-pop strobes.
- The top level holds the flag register and the per-flag priority logic.

Test Plan (NUM_FLAGS=2, SHAD_DEPTH=4):
1. Reset, then FLG_SET=2'b11 for one cycle → FLAGS=2'b11. Then FLG_CLR=2'b01 with FLG_LD=2'b01 and FLG_IN=2'b00 → FLAGS=2'b10 (CLR wins).
2. FLAGS=2'b01, FLG_PUSH with FLG_LD=2'b11 and FLG_IN=2'b10 → FLAGS=2'b10, entry0=2'b01, SHAD_COUNT=1. Next cycle FLG_POP with FLG_SET=2'b11 → FLAGS=2'b01, SHAD_COUNT=0, SHAD_EMPTY=1.
3. Four pushes of 2'b00, 2'b01, 2'b10, 2'b11 → SHAD_FULL=1. A fifth push → SHAD_OVF=1, count stays 4. Then four pops → FLAGS sequence 2'b11, 2'b10, 2'b01, 2'b00.
4. Pop while empty → SHAD_UNF=1, FLAGS unchanged. ERR_CLR → SHAD_UNF=0. ERR_CLR plus another empty pop in the same cycle → SHAD_UNF stays 1.
5. Count=1, entry0=2'b10, FLAGS=2'b01, PUSH+POP together → FLAGS=2'b10, entry0=2'b01, count=1.
6. Assert RST_N low between clock edges after two pushes → FLAGS=0, SHAD_COUNT=0, SHAD_EMPTY=1 immediately, without waiting for a CLK edge.
